// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer and its controller.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_op_t;

endpackage

// File: rtl/return_stack.sv
// Parametrised LIFO of return addresses; a push when full or a pop when empty is ignored.
module return_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DW-1:0]    depth_r;
  logic [DW-1:0]    top_s;

  assign full  = (depth_r == DW'(DEPTH));
  assign empty = (depth_r == {DW{1'b0}});
  assign top_s = depth_r - DW'(1);
  assign depth = depth_r;

  // Entry storage; contents survive reset and become unreachable once depth is cleared.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem_r[depth_r[IW-1:0]] <= din;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_r <= {DW{1'b0}};
    end else if (push && !full) begin
      depth_r <= depth_r + DW'(1);
    end else if (pop && !empty) begin
      depth_r <= depth_r - DW'(1);
    end else begin
      depth_r <= depth_r;
    end
  end

  // Top-of-stack read; an empty stack presents zero rather than a stale slot.
  always_comb begin
    if (empty) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem_r[top_s[IW-1:0]];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with next-PC selection, return-address stack and sticky
// overflow/underflow flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    OFFSET_WIDTH = 8,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = {ADDR_WIDTH{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  pc_op_t                           op,
  input  logic                             cond,
  input  logic [ADDR_WIDTH-1:0]            target,
  input  logic [OFFSET_WIDTH-1:0]          offset,
  input  logic                             stall,
  input  logic                             clear_err,
  output logic [ADDR_WIDTH-1:0]            pc,
  output logic [ADDR_WIDTH-1:0]            pc_plus1,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             overflow_err,
  output logic                             underflow_err
);

  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_next_s;
  logic [ADDR_WIDTH-1:0] ret_addr_s;
  logic [ADDR_WIDTH-1:0] offset_ext_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ovf_evt_s;
  logic                  unf_evt_s;
  logic                  ovf_r;
  logic                  unf_r;

  assign pc_plus1      = pc_r + ADDR_WIDTH'(1);
  assign offset_ext_s  = ADDR_WIDTH'($signed(offset));
  assign pc            = pc_r;
  assign overflow_err  = ovf_r;
  assign underflow_err = unf_r;

  return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_plus1),
    .dout  (ret_addr_s),
    .depth (depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Next-PC selection, stack control and error events for the current op.
  always_comb begin
    pc_next_s = pc_plus1;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_evt_s = 1'b0;
    unf_evt_s = 1'b0;
    if (stall) begin
      pc_next_s = pc_r;
    end else begin
      case (op)
        PC_JUMP: pc_next_s = target;
        PC_BRANCH: begin
          if (cond) begin
            pc_next_s = pc_plus1 + offset_ext_s;
          end else begin
            pc_next_s = pc_plus1;
          end
        end
        PC_CALL: begin
          if (stack_full) begin
            ovf_evt_s = 1'b1;
          end else begin
            push_s    = 1'b1;
            pc_next_s = target;
          end
        end
        PC_RET: begin
          if (stack_empty) begin
            unf_evt_s = 1'b1;
          end else begin
            pop_s     = 1'b1;
            pc_next_s = ret_addr_s;
          end
        end
        default: pc_next_s = pc_plus1;
      endcase
    end
  end

  // PC register and sticky error flags; a new error event beats clear_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r  <= RESET_VECTOR;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      pc_r  <= pc_next_s;
      ovf_r <= ovf_evt_s | (ovf_r & ~clear_err);
      unf_r <= unf_evt_s | (unf_r & ~clear_err);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// literal expectations from hand-worked scenarios.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int AW  = 12;
  localparam int OW  = 8;
  localparam int SD  = 8;
  localparam int DW  = 4;
  localparam int MOD = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  pc_op_t        op = PC_NEXT;
  logic          cond = 1'b0;
  logic [AW-1:0] target = '0;
  logic [OW-1:0] offset = '0;
  logic          stall = 1'b0;
  logic          clear_err = 1'b0;

  logic [AW-1:0] pc, pc_plus1, pc_rv, pc_plus1_rv;
  logic [DW-1:0] depth, depth_rv;
  logic          stack_full, stack_empty, overflow_err, underflow_err;
  logic          full_rv, empty_rv, ovf_rv, unf_rv;

  int  tests = 0;
  int  fails = 0;
  int  pc_m = 0;
  int  stk[$];
  bit  ovf_m = 1'b0;
  bit  unf_m = 1'b0;
  bit  model_valid = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .STACK_DEPTH(SD), .RESET_VECTOR(12'h000)) dut (
    .clk(clk), .rst(rst), .op(op), .cond(cond), .target(target), .offset(offset),
    .stall(stall), .clear_err(clear_err), .pc(pc), .pc_plus1(pc_plus1), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  pc_sequencer #(.ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .STACK_DEPTH(SD), .RESET_VECTOR(12'h100)) dut_rv (
    .clk(clk), .rst(rst), .op(op), .cond(cond), .target(target), .offset(offset),
    .stall(stall), .clear_err(clear_err), .pc(pc_rv), .pc_plus1(pc_plus1_rv), .depth(depth_rv),
    .stack_full(full_rv), .stack_empty(empty_rv),
    .overflow_err(ovf_rv), .underflow_err(unf_rv)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one clock edge, from the operation rules.
  task automatic model_step();
    int nxt1;
    int off;
    nxt1 = (pc_m + 1) % MOD;
    if (rst) begin
      pc_m = 0;
      stk.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (clear_err) begin
        ovf_m = 1'b0;
        unf_m = 1'b0;
      end
      if (!stall) begin
        case (int'(op))
          1: pc_m = int'(target);
          2: begin
            off = int'(offset);
            if (off >= 128) off = off - 256;
            pc_m = cond ? (nxt1 + off + MOD) % MOD : nxt1;
          end
          3: begin
            if (stk.size() == SD) begin
              ovf_m = 1'b1;
              pc_m = nxt1;
            end else begin
              stk.push_back(nxt1);
              pc_m = int'(target);
            end
          end
          4: begin
            if (stk.size() == 0) begin
              unf_m = 1'b1;
              pc_m = nxt1;
            end else begin
              pc_m = stk.pop_back();
            end
          end
          default: pc_m = nxt1;
        endcase
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic cyc(input logic r, input pc_op_t o, input logic c, input int t,
                     input int ofs, input logic s, input logic ce);
    rst = r; op = o; cond = c; target = AW'(t); offset = OW'(ofs);
    stall = s; clear_err = ce;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("pc", int'(pc), pc_m);
      chk("pc_plus1", int'(pc_plus1), (pc_m + 1) % MOD);
      chk("depth", int'(depth), stk.size());
      chk("stack_full", int'(stack_full), int'(stk.size() == SD));
      chk("stack_empty", int'(stack_empty), int'(stk.size() == 0));
      chk("overflow_err", int'(overflow_err), int'(ovf_m));
      chk("underflow_err", int'(underflow_err), int'(unf_m));
    end
  end

  initial begin
    int exp_ret;
    int r;
    // Reset and sequential fetch.
    cyc(1'b1, PC_NEXT, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc(1'b1, PC_NEXT, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_pc_vector", int'(pc_rv), 'h100);
    chk("rst_empty", int'(stack_empty), 1);
    chk("rst_errs", int'({overflow_err, underflow_err}), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, PC_NEXT, 1'b0, 0, 0, 1'b0, 1'b0);
      chk("next_pc", int'(pc), i + 1);
    end

    // Relative branches, including wrap past the top of the address space.
    cyc(1'b0, PC_JUMP, 1'b0, 'h010, 0, 1'b0, 1'b0);
    cyc(1'b0, PC_BRANCH, 1'b1, 0, 'hFC, 1'b0, 1'b0);
    chk("branch_back", int'(pc), 'h00D);
    cyc(1'b0, PC_JUMP, 1'b0, 'h010, 0, 1'b0, 1'b0);
    cyc(1'b0, PC_BRANCH, 1'b0, 0, 'hFC, 1'b0, 1'b0);
    chk("branch_not_taken", int'(pc), 'h011);
    cyc(1'b0, PC_JUMP, 1'b0, 'hFFF, 0, 1'b0, 1'b0);
    cyc(1'b0, PC_BRANCH, 1'b1, 0, 2, 1'b0, 1'b0);
    chk("branch_wrap", int'(pc), 'h002);

    // Two-level call/return.
    cyc(1'b0, PC_JUMP, 1'b0, 'h020, 0, 1'b0, 1'b0);
    cyc(1'b0, PC_CALL, 1'b0, 'h300, 0, 1'b0, 1'b0);
    chk("call1_pc", int'(pc), 'h300);
    chk("call1_depth", int'(depth), 1);
    cyc(1'b0, PC_CALL, 1'b0, 'h400, 0, 1'b0, 1'b0);
    chk("call2_pc", int'(pc), 'h400);
    chk("call2_depth", int'(depth), 2);
    cyc(1'b0, PC_RET, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("ret1_pc", int'(pc), 'h301);
    chk("ret1_depth", int'(depth), 1);
    cyc(1'b0, PC_RET, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("ret2_pc", int'(pc), 'h021);
    chk("ret2_depth", int'(depth), 0);

    // Fill the stack, overflow once, then unwind all eight levels.
    cyc(1'b0, PC_JUMP, 1'b0, 'h030, 0, 1'b0, 1'b0);
    for (int k = 1; k <= SD; k++) cyc(1'b0, PC_CALL, 1'b0, 'h048 + k, 0, 1'b0, 1'b0);
    chk("fill_full", int'(stack_full), 1);
    chk("fill_pc", int'(pc), 'h050);
    cyc(1'b0, PC_CALL, 1'b0, 'h700, 0, 1'b0, 1'b0);
    chk("ovf_pc", int'(pc), 'h051);
    chk("ovf_flag", int'(overflow_err), 1);
    chk("ovf_depth", int'(depth), SD);
    for (int k = SD; k >= 1; k--) begin
      exp_ret = (k == 1) ? 'h031 : 'h048 + k;
      cyc(1'b0, PC_RET, 1'b0, 0, 0, 1'b0, 1'b0);
      chk("unwind_pc", int'(pc), exp_ret);
      chk("unwind_depth", int'(depth), k - 1);
    end
    cyc(1'b0, PC_NEXT, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("ovf_cleared", int'(overflow_err), 0);

    // Underflow, clear, and set-wins-over-clear.
    cyc(1'b0, PC_JUMP, 1'b0, 'h005, 0, 1'b0, 1'b0);
    cyc(1'b0, PC_RET, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("unf_pc", int'(pc), 'h006);
    chk("unf_flag", int'(underflow_err), 1);
    cyc(1'b0, PC_NEXT, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("unf_cleared", int'(underflow_err), 0);
    cyc(1'b0, PC_RET, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("unf_set_wins", int'(underflow_err), 1);
    cyc(1'b0, PC_NEXT, 1'b0, 0, 0, 1'b0, 1'b1);

    // Stall holds a pending call, which then executes exactly once.
    cyc(1'b0, PC_JUMP, 1'b0, 'h0AA, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, PC_CALL, 1'b0, 'h200, 0, 1'b1, 1'b0);
      chk("stall_pc", int'(pc), 'h0AA);
      chk("stall_depth", int'(depth), 0);
    end
    cyc(1'b0, PC_CALL, 1'b0, 'h200, 0, 1'b0, 1'b0);
    chk("unstall_pc", int'(pc), 'h200);
    chk("unstall_depth", int'(depth), 1);
    cyc(1'b0, PC_CALL, 1'b0, 'h210, 0, 1'b0, 1'b0);
    cyc(1'b0, PC_CALL, 1'b0, 'h220, 0, 1'b0, 1'b0);
    chk("chain_depth", int'(depth), 3);
    cyc(1'b1, PC_CALL, 1'b0, 'h230, 0, 1'b1, 1'b0);
    chk("midchain_rst_pc", int'(pc), 0);
    chk("midchain_rst_depth", int'(depth), 0);

    // Randomised traffic, including undefined encodings, stalls and resets.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 199));
      cyc(r == 0, pc_op_t'(3'($urandom_range(0, 7))), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 255)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
